// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and framing constants for the instruction-memory loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, BYTE, WRITE, CHK, DONE, ERR} loader_state_t;
    localparam int WORD_BYTES = 3;
    localparam int HDR_BYTES  = 2;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: packs WORD_BYTES stream bytes (MSB first) into one instruction word.
// Ports: clk, rst_n (async active-low), i_clr (restart byte count), i_take (byte accepted),
//        i_byte (stream byte), o_last (next accepted byte completes a word),
//        o_word (shift register), o_word_valid (one-cycle pulse after the word completes).
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = 8 * WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_take,
    input  logic [7:0]        i_byte,
    output logic              o_last,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid
);
    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_sr;
    logic              r_valid;
    assign o_last       = (r_cnt == 2'(WORD_BYTES - 1));
    assign o_word       = r_sr;
    assign o_word_valid = r_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_sr    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_take && o_last;
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_take) begin
                r_cnt <= o_last ? 2'd0 : r_cnt + 2'd1;
                r_sr  <= {r_sr[WORD_W-9:0], i_byte};
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader filling instruction memory from a byte stream, holding the CPU until done.
// Ports: clk, rst_n (async active-low), start (load pulse), in_data/in_valid/in_ready (byte stream),
//        imem_we/imem_addr/imem_wdata (memory write port), cpu_run (CPU release), busy, error,
//        words_loaded (words written in this load).
// Option: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the payload.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 140,
    parameter int WORD_W = 24,
    parameter int ADDR_W = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [WORD_W-1:0]          imem_wdata,
    output logic                       cpu_run,
    output logic                       busy,
    output logic                       error,
    output logic [$clog2(DEPTH+1)-1:0] words_loaded
);
    localparam int IW = $clog2(DEPTH + 1);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t FINAL = CHK;
    logic [7:0] r_xor;
`else
    localparam loader_state_t FINAL = DONE;
`endif
    loader_state_t r_state;
    logic [15:0]   r_count;
    logic [IW-1:0] r_index;
    logic          w_take;
    logic          w_restart;
    logic          w_last_byte;
    logic          w_last_word;
    logic [15:0]   w_count;
    assign w_take      = in_valid && in_ready;
    assign w_restart   = start && (r_state inside {IDLE, DONE, ERR});
    assign w_count     = {r_count[15:8], in_data};
    assign w_last_word = (16'(r_index) + 16'd1 == r_count);
    byte_packer #(.WORD_W(WORD_W)) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_restart),
        .i_take      (w_take && r_state == BYTE),
        .i_byte      (in_data),
        .o_last      (w_last_byte),
        .o_word      (imem_wdata),
        .o_word_valid(imem_we)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_index <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE, ERR: if (w_restart) begin
                    r_state <= HDR_HI;
                    r_count <= '0;
                    r_index <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_xor   <= '0;
`endif
                end
                HDR_HI: if (w_take) begin
                    r_count[15:8] <= in_data;
                    r_state       <= HDR_LO;
                end
                HDR_LO: if (w_take) begin
                    r_count <= w_count;
                    r_state <= (w_count == 16'd0) ? FINAL : (w_count > DEPTH16) ? ERR : BYTE;
                end
                BYTE: if (w_take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_xor <= r_xor ^ in_data;
`endif
                    if (w_last_byte) r_state <= WRITE;
                end
                // The packer raises imem_we during this cycle; only the bookkeeping lives here.
                WRITE: begin
                    r_index <= r_index + IW'(1);
                    r_state <= w_last_word ? FINAL : BYTE;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: if (w_take) r_state <= (in_data == r_xor) ? DONE : ERR;
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
    assign in_ready     = r_state inside {HDR_HI, HDR_LO, BYTE, CHK};
    assign busy         = r_state inside {HDR_HI, HDR_LO, BYTE, WRITE, CHK};
    assign cpu_run      = (r_state == DONE);
    assign error        = (r_state == ERR);
    assign imem_addr    = {{(ADDR_W-IW-2){1'b0}}, r_index, 2'b00};
    assign words_loaded = r_index;
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller that fills the 24-bit instruction memory of the single-cycle processor from a byte stream (UART or debug port) and holds the processor stopped until the program is complete. It accepts a 2-byte word-count header and then 3 bytes per instruction. It packs each instruction into a word, issues one word-aligned write per instruction, and then releases the CPU. It sits between the host byte source, the write port of the instruction memory and the processor run/reset control.

## Interface
- `DEPTH`, 140: instruction memory depth in words.
- `WORD_W`, 24: instruction width; always 3 bytes.
- `ADDR_W`, 24: byte-address width of the memory port.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a load.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: instruction memory write strobe.
- `imem_addr` output ADDR_W: byte address, word-aligned (`word_index<<2`, bits [1:0]=0).
- `imem_wdata` output WORD_W: assembled instruction.
- `cpu_run` output 1: 1 lets the processor fetch; 0 holds it in reset.
- `busy` output 1: a load is in progress.
- `error` output 1: the load was aborted.
- `words_loaded` output $clog2(DEPTH+1): number of words written in the current load.

## Operation
- States: IDLE, HDR_HI, HDR_LO, BYTE, WRITE, (CHK), DONE, ERR.
- IDLE: `start` goes to HDR_HI. The count, index, byte counter and `words_loaded` clear.
- HDR_HI / HDR_LO: accept the count MSB, then the LSB, into a 16-bit `count`.
- After HDR_LO:
  - count==0 goes to DONE (or CHK).
  - count>DEPTH goes to ERR.
  - otherwise goes to BYTE.
- BYTE: accept 3 bytes, most significant first. The shift register is `{sr[15:0],in_data}`. After the third accepted byte, go to WRITE.
- WRITE (one cycle):
  - `imem_we`=1, `imem_addr`=`index<<2`, `imem_wdata`=sr.
  - index and `words_loaded` increment.
  - Then go to DONE (or CHK) if index+1==count, else back to BYTE.
- DONE: `cpu_run`=1 and it stays 1.
- ERR: `error`=1 and `cpu_run`=0.
- `start` in DONE or ERR restarts the load (back to HDR_HI). `start` in any other state is ignored.
- `busy`=1 in HDR_HI, HDR_LO, BYTE, WRITE and CHK.
- A byte is consumed only on `in_valid && in_ready`. `in_valid` low stalls any state indefinitely with no timeout.

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `busy`=0, `error`=0, `words_loaded`=0. State is IDLE.
- All outputs are registered or pure functions of state. There is no combinational path from `in_valid` to `in_ready`.
- `in_ready` is 1 exactly in HDR_HI, HDR_LO, BYTE and CHK, so 1 byte is accepted per cycle there.
- `in_ready` is 0 in WRITE. Each word therefore costs at least 4 cycles.
- The third byte is accepted in cycle N. The write occurs in cycle N+1. For the last word, `cpu_run`=1 from cycle N+2.
- The entry cycle into DONE sets `cpu_run`. A restart `start` in DONE drops `cpu_run` the next cycle.
- Reset mid-load: everything returns to its reset value immediately. Words already written stay in memory, and a new `start` is required.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last word, the CHK state accepts 1 byte.
  - If that byte equals the XOR of all payload bytes (header excluded), go to DONE; otherwise go to ERR.
  - count==0 expects a checksum of 0x00.
- Not defined: the CHK state and the XOR accumulator do not exist. The last WRITE goes straight to DONE.

## Structure
- Shared package `imem_loader_pkg`: state enum `loader_state_t`, `WORD_BYTES`=3, `HDR_BYTES`=2.
- Sub-module `byte_packer`: 3-byte shift register, byte counter and `word_valid` pulse. The main FSM stays in `imem_loader`.
- Memory arbitration at top level: write port driven by the loader while `cpu_run`=0; fetch used only when `cpu_run`=1.

## Test plan
- Nominal load: `start`, then header 0x0002, then bytes E6 81 00, E6 81 00. Expect writes at addr 0x0 and 0x4, both with data 0xE68100. Expect `cpu_run`=1 two cycles after the last byte and `words_loaded`=2.
- Gapped stream: the same program with `in_valid` toggling every cycle. Expect identical writes and no duplicated or dropped bytes.
- Oversize: header 0x008D (141). Expect ERR with `error`=1, no `imem_we` and `cpu_run`=0. Then `start` with header 0x0000 reaches DONE.
- Full depth: 140 words. Expect the last write at addr 0x22C (139<<2) and `words_loaded`=140.
- Reset mid-word: assert `rst_n`=0 after 2 payload bytes. Expect all outputs at reset values and no partial write.
- Checksum (macro on): payload E6 81 00 with checksum byte 0x67 reaches DONE. Checksum 0x66 reaches ERR.
